// File: rtl/arrow_pkg.sv
// Shared types and constants for the arrow lane renderers.
// Sprite geometry, colour indices and flash FSM states.
package arrow_pkg;

  localparam int unsigned SPRITE_W_C     = 40;
  localparam int unsigned SPRITE_H_C     = 40;
  localparam int unsigned BITMAP_BITS_C  = 1600;

  typedef enum logic [1:0] {
    CLR_NONE   = 2'd0,
    CLR_NORMAL = 2'd1,
    CLR_FLASH  = 2'd2
  } color_idx_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLASH = 2'd1,
    DONE  = 2'd2
  } flash_state_t;

endpackage

// File: rtl/frame_edge_sync.sv
// Two-flop synchronizer for a level frame strobe plus a
// one-cycle pulse on each synchronized rising edge.
module frame_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic edge_o
);

  logic [2:0] sync_q;
  logic [2:0] sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end

  assign edge_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/arrow_sprite_renderer.sv
// Per-pixel arrow lookup with per-frame shadowing and hit flash.
// Optional ARROW_MIRROR_EN adds a horizontal-flip input.
module arrow_sprite_renderer
  import arrow_pkg::*;
#(
  parameter int unsigned SPRITE_W     = SPRITE_W_C,
  parameter int unsigned SPRITE_H     = SPRITE_H_C,
  parameter int unsigned FLASH_FRAMES = 8
) (
  input  logic                         Clk,
  input  logic                         Reset_n,
  input  logic                         frame_clk,
  input  logic [9:0]                   DrawX,
  input  logic [9:0]                   DrawY,
  input  logic [9:0]                   drop_x,
  input  logic [9:0]                   drop_y,
  input  logic [SPRITE_W*SPRITE_H-1:0] arrow,
  input  logic                         score,
`ifdef ARROW_MIRROR_EN
  input  logic                         mirror,
`endif
  output logic                         arrow_on,
  output logic [1:0]                   color_idx,
  output logic                         hit_flash
);

  localparam int unsigned BITS = SPRITE_W * SPRITE_H;

  logic frame_edge;

  frame_edge_sync u_sync (
    .clk    (Clk),
    .rst_n  (Reset_n),
    .async_i(frame_clk),
    .edge_o (frame_edge)
  );

  logic [9:0]      sx_q, sx_d, sy_q, sy_d;
  logic [BITS-1:0] sbm_q, sbm_d;
  logic            sscore_q, sscore_d;
  logic            smir_q, smir_d;
  flash_state_t    state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            in_box_q, in_box_d;
  logic [10:0]     idx_q, idx_d;
  logic            on_q, on_d;
  color_idx_t      color_q, color_d;

  // Shadows only move on the frame edge so one frame never tears.
  always_comb begin
    sx_d     = sx_q;
    sy_d     = sy_q;
    sbm_d    = sbm_q;
    sscore_d = sscore_q;
    smir_d   = smir_q;
    if (frame_edge) begin
      sx_d     = drop_x;
      sy_d     = drop_y;
      sbm_d    = arrow;
      sscore_d = score;
`ifdef ARROW_MIRROR_EN
      smir_d   = mirror;
`else
      smir_d   = 1'b0;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (frame_edge) begin
      unique case (state_q)
        IDLE: begin
          if (score && !sscore_q) begin
            cnt_d   = 8'(FLASH_FRAMES - 1);
            state_d = FLASH;
          end
        end
        FLASH: begin
          if (cnt_q == 8'd0) state_d = DONE;
          else               cnt_d   = cnt_q - 8'd1;
        end
        DONE: begin
          if (!score) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  logic [10:0] x11, y11, sx11, sy11, col11;
  logic [9:0]  dx, dy;

  // Eleven-bit compares keep a right-clipped sprite from wrapping.
  always_comb begin
    x11      = {1'b0, DrawX};
    y11      = {1'b0, DrawY};
    sx11     = {1'b0, sx_q};
    sy11     = {1'b0, sy_q};
    dx       = DrawX - sx_q;
    dy       = DrawY - sy_q;
    in_box_d = (x11 >= sx11) && (x11 < sx11 + 11'(SPRITE_W)) &&
               (y11 >= sy11) && (y11 < sy11 + 11'(SPRITE_H));
    col11    = {1'b0, dx};
    if (smir_q) col11 = 11'(SPRITE_W - 1) - {1'b0, dx};
    idx_d    = {1'b0, dy} * 11'(SPRITE_W) + col11;
  end

  always_comb begin
    on_d = in_box_q && (idx_q < 11'(BITS)) && sbm_q[idx_q];
    if (!on_d)                color_d = CLR_NONE;
    else if (state_q == FLASH) color_d = CLR_FLASH;
    else                      color_d = CLR_NORMAL;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sx_q     <= '0;
      sy_q     <= '0;
      sbm_q    <= '0;
      sscore_q <= 1'b0;
      smir_q   <= 1'b0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      in_box_q <= 1'b0;
      idx_q    <= '0;
      on_q     <= 1'b0;
      color_q  <= CLR_NONE;
    end else begin
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      sbm_q    <= sbm_d;
      sscore_q <= sscore_d;
      smir_q   <= smir_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      in_box_q <= in_box_d;
      idx_q    <= idx_d;
      on_q     <= on_d;
      color_q  <= color_d;
    end
  end

  assign arrow_on  = on_q;
  assign color_idx = color_q;
  assign hit_flash = (state_q == FLASH);

endmodule

// File: tb/tb_arrow_sprite_renderer.sv
// Randomized self-checking bench for arrow_sprite_renderer
// against a frame-level behavioural model.
module tb_arrow_sprite_renderer;

  localparam int W = 40;
  localparam int H = 40;
  localparam int FF = 4;

  logic          Clk = 1'b0;
  logic          Reset_n;
  logic          frame_clk;
  logic [9:0]    DrawX, DrawY, drop_x, drop_y;
  logic [1599:0] arrow;
  logic          score;
  logic          mirror;
  logic          arrow_on;
  logic [1:0]    color_idx;
  logic          hit_flash;

  int n_chk = 0;
  int n_err = 0;

  // model state: what the design should have latched last frame
  int            m_sx, m_sy;
  logic [1599:0] m_bm;
  bit            m_mir;
  bit            m_prev;
  int            m_flash_left;
  bit            m_wait_low;

  always #5 Clk = ~Clk;

  arrow_sprite_renderer #(
    .SPRITE_W    (W),
    .SPRITE_H    (H),
    .FLASH_FRAMES(FF)
  ) dut (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .frame_clk(frame_clk),
    .DrawX    (DrawX),
    .DrawY    (DrawY),
    .drop_x   (drop_x),
    .drop_y   (drop_y),
    .arrow    (arrow),
    .score    (score),
`ifdef ARROW_MIRROR_EN
    .mirror   (mirror),
`endif
    .arrow_on (arrow_on),
    .color_idx(color_idx),
    .hit_flash(hit_flash)
  );

  function automatic bit m_pix(input int x, input int y);
    int col;
    if (x < m_sx || x >= m_sx + W || y < m_sy || y >= m_sy + H)
      return 1'b0;
    col = x - m_sx;
    if (m_mir) col = W - 1 - col;
    return m_bm[(y - m_sy) * W + col];
  endfunction

  function automatic logic [1:0] m_color(input int x, input int y);
    if (!m_pix(x, y)) return 2'd0;
    return (m_flash_left > 0) ? 2'd2 : 2'd1;
  endfunction

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_bm = '0; m_mir = 0;
    m_prev = 0; m_flash_left = 0; m_wait_low = 0;
  endtask

  task automatic apply_frame();
    @(negedge Clk);
    frame_clk = 1'b1;
    repeat (5) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    m_sx = int'(drop_x);
    m_sy = int'(drop_y);
    m_bm = arrow;
`ifdef ARROW_MIRROR_EN
    m_mir = mirror;
`endif
    if (m_flash_left > 0) m_flash_left--;
    else if (m_wait_low) begin
      if (!score) m_wait_low = 0;
    end else if (score && !m_prev) begin
      m_flash_left = FF;
      m_wait_low   = 1;
    end
    m_prev = score;
  endtask

  task automatic drive_pix(input int x, input int y);
    @(negedge Clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    @(posedge Clk);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    n_chk++;
    if (arrow_on !== 1'b0) begin
      n_err++; $display("FAIL reset_arrow_on got %b want 0", arrow_on);
    end
    n_chk++;
    if (color_idx !== 2'd0) begin
      n_err++; $display("FAIL reset_color got %0d want 0", color_idx);
    end
    n_chk++;
    if (hit_flash !== 1'b0) begin
      n_err++; $display("FAIL reset_flash got %b want 0", hit_flash);
    end
  endtask

  task automatic test_pixel_hit();
    arrow = '0; arrow[420] = 1'b1;
    drop_x = 10'd160; drop_y = 10'd100;
    apply_frame();
    drive_pix(179, 110);
    n_chk++;
    if (arrow_on !== m_pix(179, 110) || arrow_on !== 1'b0) begin
      n_err++; $display("FAIL hit_179 got %b want 0", arrow_on);
    end
    @(negedge Clk);
    DrawX = 10'd180; DrawY = 10'd110;
    @(posedge Clk); #1;
    n_chk++;
    if (arrow_on !== 1'b0) begin
      n_err++; $display("FAIL hit_lat1 got %b want 0", arrow_on);
    end
    @(posedge Clk); #1;
    n_chk++;
    if (arrow_on !== 1'b1) begin
      n_err++; $display("FAIL hit_lat2 got %b want 1", arrow_on);
    end
    n_chk++;
    if (color_idx !== 2'd1) begin
      n_err++; $display("FAIL hit_color got %0d want 1", color_idx);
    end
  endtask

  task automatic test_edges();
    int px[9];
    int py[9];
    px = '{199, 200, 170, 170, 160, 159, 5, 630, 659};
    py = '{110, 110, 139, 140, 100, 100, 110, 110, 110};
    arrow = '1;
    drop_x = 10'd160; drop_y = 10'd100;
    apply_frame();
    for (int i = 0; i < 9; i++) begin
      if (i == 6) begin
        drop_x = 10'd620;
        apply_frame();
      end
      drive_pix(px[i], py[i]);
      n_chk++;
      if (arrow_on !== m_pix(px[i], py[i])) begin
        n_err++;
        $display("FAIL edge_%0d_%0d got %b want %b",
                 px[i], py[i], arrow_on, m_pix(px[i], py[i]));
      end
    end
  endtask

  task automatic test_tear_free();
    drop_x = 10'd160; drop_y = 10'd100;
    apply_frame();
    drop_y = 10'd150;
    repeat (3) @(negedge Clk);
    drive_pix(170, 110);
    n_chk++;
    if (arrow_on !== 1'b1) begin
      n_err++; $display("FAIL tear_old got %b want 1", arrow_on);
    end
    drive_pix(170, 160);
    n_chk++;
    if (arrow_on !== 1'b0) begin
      n_err++; $display("FAIL tear_early got %b want 0", arrow_on);
    end
    apply_frame();
    drive_pix(170, 160);
    n_chk++;
    if (arrow_on !== 1'b1) begin
      n_err++; $display("FAIL tear_new got %b want 1", arrow_on);
    end
    drive_pix(170, 110);
    n_chk++;
    if (arrow_on !== 1'b0) begin
      n_err++; $display("FAIL tear_stale got %b want 0", arrow_on);
    end
  endtask

  task automatic test_random_pixels();
    int x, y;
    for (int it = 0; it < 12; it++) begin
      for (int w = 0; w < 50; w++) arrow[w*32 +: 32] = $urandom;
      drop_x = 10'($urandom_range(0, 639));
      drop_y = 10'($urandom_range(0, 479));
      apply_frame();
      for (int k = 0; k < 6; k++) begin
        x = (int'(drop_x) + int'($urandom_range(0, 45)) - 3) & 1023;
        y = (int'(drop_y) + int'($urandom_range(0, 45)) - 3) & 1023;
        drive_pix(x, y);
        n_chk++;
        if (arrow_on !== m_pix(x, y) || color_idx !== m_color(x, y)) begin
          n_err++;
          $display("FAIL rand_%0d_%0d got %b/%0d want %b/%0d", x, y,
                   arrow_on, color_idx, m_pix(x, y), m_color(x, y));
        end
      end
    end
  endtask

  task automatic test_flash();
    int seen;
    arrow = '1;
    drop_x = 10'd160; drop_y = 10'd100;
    score = 1'b1;
    seen = 0;
    for (int f = 0; f < 11; f++) begin
      if (f == 7) score = 1'b0;
      if (f == 8) score = 1'b1;
      apply_frame();
      if (f < 7 && hit_flash === 1'b1) seen++;
      n_chk++;
      if (hit_flash !== (m_flash_left > 0)) begin
        n_err++; $display("FAIL flash_f%0d got %b want %b",
                          f, hit_flash, m_flash_left > 0);
      end
      drive_pix(170, 110);
      n_chk++;
      if (color_idx !== m_color(170, 110)) begin
        n_err++; $display("FAIL flash_color_f%0d got %0d want %0d",
                          f, color_idx, m_color(170, 110));
      end
    end
    n_chk++;
    if (seen != FF) begin
      n_err++; $display("FAIL flash_len got %0d want %0d", seen, FF);
    end
    n_chk++;
    if (hit_flash !== 1'b1) begin
      n_err++; $display("FAIL flash_retrig got %b want 1", hit_flash);
    end
  endtask

  task automatic test_reset_mid_flash();
    score = 1'b0;
    repeat (6) apply_frame();
    score = 1'b1;
    apply_frame();
    apply_frame();
    drive_pix(170, 110);
    n_chk++;
    if (color_idx !== 2'd2 || hit_flash !== 1'b1) begin
      n_err++; $display("FAIL rmf_pre got %0d/%b want 2/1",
                        color_idx, hit_flash);
    end
    #2 Reset_n = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if ({arrow_on, color_idx, hit_flash} !== 4'b0) begin
      n_err++; $display("FAIL rmf_async got %b want 0000",
                        {arrow_on, color_idx, hit_flash});
    end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    score = 1'b0;
    drive_pix(170, 110);
    n_chk++;
    if (hit_flash !== 1'b0 || arrow_on !== m_pix(170, 110)) begin
      n_err++; $display("FAIL rmf_after got %b/%b want 0/0",
                        hit_flash, arrow_on);
    end
    apply_frame();
    drive_pix(170, 110);
    n_chk++;
    if (hit_flash !== 1'b0 || color_idx !== m_color(170, 110)) begin
      n_err++; $display("FAIL rmf_idle got %b/%0d want 0/%0d",
                        hit_flash, color_idx, m_color(170, 110));
    end
  endtask

  task automatic test_mirror();
`ifdef ARROW_MIRROR_EN
    arrow = '0; arrow[420] = 1'b1;
    drop_x = 10'd160; drop_y = 10'd100;
    mirror = 1'b1;
    apply_frame();
    drive_pix(179, 110);
    n_chk++;
    if (arrow_on !== 1'b1 || arrow_on !== m_pix(179, 110)) begin
      n_err++; $display("FAIL mirror_179 got %b want 1", arrow_on);
    end
    drive_pix(180, 110);
    n_chk++;
    if (arrow_on !== 1'b0) begin
      n_err++; $display("FAIL mirror_180 got %b want 0", arrow_on);
    end
    mirror = 1'b0;
    apply_frame();
`endif
  endtask

  initial begin
    Reset_n = 1'b0; frame_clk = 1'b0;
    DrawX = '0; DrawY = '0; drop_x = '0; drop_y = '0;
    arrow = '0; score = 1'b0; mirror = 1'b0;
    model_reset();
    repeat (3) @(negedge Clk);
    test_reset();
    Reset_n = 1'b1;
    test_pixel_hit();
    test_edges();
    test_tear_free();
    test_random_pixels();
    test_flash();
    test_reset_mid_flash();
    test_mirror();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
